uart_fifo_tx: RTL and testbench
===============================

UART_FIFO_TX -- requirements
Module: uart_fifo_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per UART bit (100 MHz / 115200); legal values are 2 or greater.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-003 SHALL have port rstn, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port din, input, 8 bits: byte from the upstream fifo, valid on the cycle after rd_en.
REQ-005 SHALL have port empty, input, 1 bit: high means the upstream fifo holds no byte.
REQ-006 SHALL have port rd_en, output, 1 bit: one-cycle pop request to the upstream fifo.
REQ-007 SHALL have port tx_data, output, 1 bit: serial UART line, idle high.
REQ-008 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-009 SHALL have port frame_done, output, 1 bit: one-cycle pulse on the last clk cycle of a stop bit.

Function
REQ-010 SHALL implement the FSM states IDLE, FETCH, START, DATA, PARITY (only when PARITY_EN is defined) and STOP.
REQ-011 IDLE: tx_data=1; if empty==0, assert rd_en for exactly this cycle and go to FETCH; otherwise stay in IDLE.
REQ-012 FETCH: lasts one cycle; latch din into an 8-bit shift register, clear the baud counter and bit index, go to START.
REQ-013 START: tx_data=0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-014 DATA: send bits 0..7 LSB first, each held CLKS_PER_BIT cycles; after bit 7, go to PARITY if enabled, otherwise to STOP.
REQ-015 STOP: tx_data=1 for CLKS_PER_BIT cycles; assert frame_done in the final cycle; then go to IDLE.
REQ-016 Baud counter SHALL count 0..CLKS_PER_BIT-1 and wrap to 0; a bit boundary is the cycle where the counter equals CLKS_PER_BIT-1.
REQ-017 Bit index SHALL be 3 bits and SHALL advance only at bit boundaries inside DATA.
REQ-018 tx_data SHALL be driven from a register, so line transitions align to the clk edge that enters a state.
REQ-019 rd_en SHALL never be asserted while empty==1, and SHALL be asserted at most once per frame.
REQ-020 Back-to-back frames: after STOP, if empty==0, the first IDLE cycle asserts rd_en. The idle-high gap between frames is therefore exactly 2 cycles (IDLE + FETCH).
REQ-021 Frame length from START entry to STOP exit SHALL be 10*CLKS_PER_BIT cycles, or 11*CLKS_PER_BIT with parity.
REQ-022 Changes on empty or din outside IDLE/FETCH SHALL be ignored; the byte in flight is held in the shift register.
REQ-023 busy SHALL rise on the cycle after rd_en and fall on the cycle after frame_done.

Reset
REQ-024 While rstn==0 at a clk edge: state=IDLE, tx_data=1, rd_en=0, busy=0, frame_done=0, and the baud counter, bit index and shift register are cleared.
REQ-025 Reset mid-frame SHALL abort the frame; the partial byte is discarded and is not re-requested from the fifo.
REQ-026 The first rd_en after reset release SHALL occur no earlier than the first cycle with rstn==1.

Configuration
REQ-027 With macro UART_TX_PARITY_EN defined: PARITY state inserted after DATA; tx_data = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles.
REQ-028 Without UART_TX_PARITY_EN: no PARITY state, no parity logic; frame is 8N1.

Verification (CLKS_PER_BIT=4)
REQ-029 Single byte: empty 1->0 with din=8'hA5 -> one rd_en pulse; after a 1-cycle FETCH, tx_data = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; frame_done at cycle 40 of the frame; busy=0 one cycle later.
REQ-030 Back-to-back: fifo holds 8'h00 then 8'hFF -> two frames with exactly 2 idle-high cycles between them; the second frame's data bits are all 1; exactly two rd_en pulses total.
REQ-031 Empty fifo: empty held 1 for 1000 cycles -> rd_en=0, tx_data=1, busy=0 throughout.
REQ-032 Reset mid-frame: rstn=0 for 1 cycle during DATA bit 3 of 8'h5A -> next edge tx_data=1, busy=0; with empty=1 no further activity; with empty=0 a new rd_en occurs the first cycle after release.
REQ-033 Parity build: din=8'h07 -> parity bit 1, frame 44 cycles; din=8'hA5 -> parity bit 0.
REQ-034 din toggled randomly during DATA -> serialized bits match the byte latched in FETCH.

Source files
------------

// File: rtl/uart_fifo_tx.sv
// UART transmitter that pops bytes from an upstream fifo and sends 8N1 frames.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module uart_fifo_tx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] din,
  input  logic       empty,
  output logic       rd_en,
  output logic       tx_data,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          bit_end;
  logic [CW-1:0] cnt_inc;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  assign bit_end = (cnt_q == CNT_MAX);
  assign cnt_inc = bit_end ? '0 : cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    rd_en      = 1'b0;
    frame_done = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d      = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!empty && rstn) begin
          rd_en   = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        shift_d = din;
        cnt_d   = '0;
        idx_d   = '0;
`ifdef UART_TX_PARITY_EN
        par_d   = ^din;
`endif
        state_d = START;
      end
      START: begin
        cnt_d = cnt_inc;
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        cnt_d = cnt_inc;
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        cnt_d = cnt_inc;
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        cnt_d = cnt_inc;
        if (bit_end) begin
          frame_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level follows the state being entered so edges line up with it.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_q;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx_data = tx_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Self-checking bench for uart_fifo_tx with a fifo model and a frame-level
// reference checker (CLKS_PER_BIT = 4).
module tb_uart_fifo_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] din;
  logic       empty;
  logic       rd_en;
  logic       tx_data;
  logic       busy;
  logic       frame_done;

  int n_chk  = 0;
  int n_fail = 0;
  int rd_cnt = 0;
  int pushed = 0;
  bit chk_en = 1'b0;

  logic [7:0] q[$];
  logic [7:0] exp_q[$];

  uart_fifo_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .rstn(rstn),
    .din(din),
    .empty(empty),
    .rd_en(rd_en),
    .tx_data(tx_data),
    .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic line_bit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
`ifdef UART_TX_PARITY_EN
    if (j == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic push(input logic [7:0] b, input bit model);
    q.push_back(b);
    pushed++;
    if (model) exp_q.push_back(b);
  endtask

  // Upstream fifo: byte appears on din the cycle after a pop, noise otherwise.
  initial begin
    bit pop;
    empty = 1'b1;
    din   = 8'h00;
    forever begin
      @(negedge clk);
      pop = rd_en;
      @(posedge clk);
      #1;
      if (pop && q.size() > 0) begin
        din = q.pop_front();
        rd_cnt++;
      end else begin
        din = 8'($urandom);
      end
      empty = (q.size() == 0);
    end
  end

  // Frame-level reference: {tx, busy, rd_en, frame_done} per cycle.
  initial begin
    logic [7:0] b;
    logic [3:0] exp;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        exp = {1'b1, 1'b0, ~empty, 1'b0};
        chk("idle", {tx_data, busy, rd_en, frame_done}, exp);
        if (rd_en) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_rd", 1, 0);
          end else begin
            b = exp_q.pop_front();
            @(negedge clk);
            chk("fetch", {tx_data, busy, rd_en, frame_done}, 4'b1100);
            for (int k = 0; k < NB * CPB; k++) begin
              @(negedge clk);
              exp = {line_bit(b, k / CPB), 1'b1, 1'b0,
                     (k == NB * CPB - 1)};
              chk($sformatf("frame_%02h_c%0d", b, k),
                  {tx_data, busy, rd_en, frame_done}, exp);
            end
          end
        end
      end
    end
  end

  task automatic wait_rd(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rd_en) begin
        ok = 1'b1;
        return;
      end
    end
    chk("wait_rd_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && q.size() == 0 && !busy) return;
    end
    chk("wait_idle_timeout", 0, 1);
  endtask

  task automatic reset_mid(input bit refill);
    bit ok;
    chk_en = 1'b0;
    push(8'h5A, 1'b0);
    wait_rd(ok);
    if (!ok) return;
    if (refill) push(8'h3C, 1'b0);
    repeat (19) @(negedge clk);
    chk("pre_rst_bit3", {tx_data, busy}, 2'b11);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    if (refill) exp_q.push_back(8'h3C);
    chk_en = 1'b1;
    @(negedge clk);
    chk($sformatf("post_rst_r%0d", refill), {tx_data, busy, rd_en},
        {1'b1, 1'b0, refill});
    if (refill) wait_idle(200);
    else repeat (20) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;
    logic       par;
  } vec_t;

  vec_t tbl[7];

  initial begin
    bit ok;
    int r0;
    tbl[0] = '{8'hA5, 10'b0101001011, 1'b0};
    tbl[1] = '{8'h00, 10'b0000000001, 1'b0};
    tbl[2] = '{8'hFF, 10'b0111111111, 1'b0};
    tbl[3] = '{8'h07, 10'b0111000001, 1'b1};
    tbl[4] = '{8'h5A, 10'b0010110101, 1'b0};
    tbl[5] = '{8'h01, 10'b0100000001, 1'b1};
    tbl[6] = '{8'h80, 10'b0000000011, 1'b1};

    rstn = 1'b0;
    push(8'h3C, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("reset_state", {tx_data, busy, rd_en, frame_done}, 4'b1000);
    end
    @(posedge clk);
    #1;
    rstn   = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("first_rd_after_rst", rd_en, 1'b1);
    wait_idle(200);

    for (int t = 0; t < 7; t++) begin
      logic e;
      push(tbl[t].data, 1'b1);
      wait_rd(ok);
      if (!ok) continue;
      @(negedge clk);
      for (int j = 0; j < NB; j++) begin
        @(negedge clk);
        if (j < 9) e = tbl[t].line[9-j];
        else if (j == NB - 1) e = tbl[t].line[0];
        else e = tbl[t].par;
        chk($sformatf("tbl%0d_bit%0d", t, j), tx_data, e);
        repeat (CPB - 1) @(negedge clk);
      end
      chk($sformatf("tbl%0d_done", t), frame_done, 1'b1);
      @(negedge clk);
      chk($sformatf("tbl%0d_busy_fall", t), busy, 1'b0);
    end
    wait_idle(200);

    r0 = rd_cnt;
    push(8'h00, 1'b1);
    push(8'hFF, 1'b1);
    wait_idle(300);
    chk("b2b_rd_pulses", rd_cnt - r0, 2);

    repeat (1000) @(negedge clk);

    reset_mid(1'b0);
    reset_mid(1'b1);

    for (int i = 0; i < 40; i++) begin
      push(8'($urandom), 1'b1);
      if ($urandom_range(0, 2) == 0)
        repeat ($urandom_range(0, 60)) @(negedge clk);
    end
    wait_idle(5000);

    chk("rd_total", rd_cnt, pushed);
    chk("fifo_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
